// File: rtl/mac_pkg.sv
// Shared types and the square-accumulate helper used by the mac_sched datapath.
package mac_pkg;

    localparam int AW = 8;
    localparam int FW = 20;

    typedef logic [AW-1:0] sample_t;
    typedef logic [FW-1:0] acc_t;

    // Returns {carry, sum} of acc + a*a, computed one bit wider than the accumulator.
    function automatic logic [FW:0] sq_acc(input sample_t a, input acc_t acc);
        logic [FW:0] sq;
        sq = (FW+1)'(a) * (FW+1)'(a);
        return sq + {1'b0, acc};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer one past the winner when the grant is consumed.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  ptr
);

    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] ptr_next;

    // Scan ptr, ptr+1, ... (mod NREQ) and grant the first active request.
    always_comb begin
        logic found;
        int   idx;
        grant    = '0;
        ptr_next = ptr_reg;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_reg) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_next   = IDW'((idx + 1) % NREQ);
            end
        end
    end

    // Pointer only moves when a grant is actually taken; otherwise it holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/mac_sched.sv
// Time-shared square-accumulate engine: one sample per cycle is granted
// round-robin, squared and added into that requester's own accumulator, and a
// tagged result is emitted when a vector's last sample has been folded in.
module mac_sched
    import mac_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 8,
    parameter int FW   = 20,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_a,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    output logic [IDW-1:0]     out_id,
    output logic [FW-1:0]      out_f,
    output logic               out_ovf
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  arb_ptr;
    logic            unused_ptr;
    logic [IDW-1:0]  grant_id;
    logic            accept;

    // Stage 1: captured sample waiting for its accumulator update.
    logic            s1_valid_reg;
    logic [AW-1:0]   s1_a_reg;
    logic [IDW-1:0]  s1_id_reg;
    logic            s1_last_reg;

    // Per-requester running sums and sticky carry flags.
    logic [FW-1:0]   acc_reg [NREQ];
    logic            ovf_reg [NREQ];

    logic [FW:0]     sum;
    logic            ovf_sel;

    logic            out_valid_reg;
    logic [IDW-1:0]  out_id_reg;
    logic [FW-1:0]   out_f_reg;
    logic            out_ovf_reg;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant),
        .ptr     (arb_ptr)
    );

    // The pointer is exported by the arbiter for observability only.
    assign unused_ptr = ^arb_ptr;

    // Grants are suppressed while reset is held so nothing is consumed then.
    assign req_ready = grant & {NREQ{reset}};
    assign accept    = |req_ready;

    // Binary index of the (single) granted requester.
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                grant_id = IDW'(i);
            end
        end
    end

    // Stage 1 captures the accepted sample with its owner and last flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_id_reg    <= '0;
            s1_last_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_a_reg    <= req_a[grant_id*AW +: AW];
                s1_id_reg   <= grant_id;
                s1_last_reg <= req_last[grant_id];
            end
        end
    end

    // Stage 2 arithmetic: the accumulator is read only here, so back-to-back
    // samples of one requester see the freshly written sum without a bypass.
    always_comb begin
        sum     = sq_acc(sample_t'(s1_a_reg), acc_t'(acc_reg[s1_id_reg]));
        ovf_sel = ovf_reg[s1_id_reg] | sum[FW];
    end

    // Accumulator update; a finished vector clears its slot for the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                acc_reg[i] <= '0;
                ovf_reg[i] <= 1'b0;
            end
        end else if (s1_valid_reg) begin
            if (s1_last_reg) begin
                acc_reg[s1_id_reg] <= '0;
                ovf_reg[s1_id_reg] <= 1'b0;
            end else begin
                acc_reg[s1_id_reg] <= sum[FW-1:0];
                ovf_reg[s1_id_reg] <= ovf_sel;
            end
        end
    end

    // Result register: strobes for one cycle per vector, payload holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_id_reg    <= '0;
            out_f_reg     <= '0;
            out_ovf_reg   <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg & s1_last_reg;
            if (s1_valid_reg && s1_last_reg) begin
                out_id_reg  <= s1_id_reg;
                out_f_reg   <= sum[FW-1:0];
                out_ovf_reg <= ovf_sel;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_id    = out_id_reg;
    assign out_f     = out_f_reg;
    assign out_ovf   = out_ovf_reg;

endmodule
